// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the radix-4 (modified Booth) sequential multiplier.
//   state_t   : controller states (IDLE, RUN)
//   digit_t   : 3-bit select code for the recoded Booth digit
//   booth_iters(): number of radix-4 iterations needed for a WIDTH-bit operand
//                  once it has been widened to WIDTH+2 bits
// ---------------------------------------------------------------------------
package booth_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Each radix-4 digit selects one of five addends: 0, +M, +2M, -M, -2M.
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    PM   = 3'd1,
    P2M  = 3'd2,
    NM   = 3'd3,
    N2M  = 3'd4
  } digit_t;

  // The operand is widened by two bits so that unsigned values stay positive
  // under signed recoding; that gives WIDTH+2 bits, i.e. WIDTH/2+1 digits.
  function automatic int booth_iters(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// ---------------------------------------------------------------------------
// booth_r4_recoder
// Combinational radix-4 Booth digit recoder. Looks at the multiplier triplet
// {Qr[1:0], q_m1} and produces the addend for this iteration, already
// sign-extended to the accumulator width.
//
// Ports
//   triplet  in  3         {Qr[1:0], q_m1}
//   mr       in  WIDTH+2   extended multiplicand M
//   addend   out WIDTH+4   0, +M, +2M, -M or -2M (two's complement)
// ---------------------------------------------------------------------------
module booth_r4_recoder
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       triplet,
  input  logic [WIDTH+1:0] mr,
  output logic [WIDTH+3:0] addend
);

  digit_t           sel;
  logic [WIDTH+3:0] m1;
  logic [WIDTH+3:0] m2;

  // M and 2M sign-extended to the accumulator width; 2M needs one extra bit,
  // the second guard bit keeps the running sum from wrapping.
  assign m1 = {{2{mr[WIDTH+1]}}, mr};
  assign m2 = {mr[WIDTH+1], mr, 1'b0};

  // Standard modified-Booth digit table.
  always_comb begin
    sel = ZERO;
    case (triplet)
      3'b001, 3'b010: sel = PM;
      3'b011:         sel = P2M;
      3'b100:         sel = N2M;
      3'b101, 3'b110: sel = NM;
      default:        sel = ZERO;
    endcase
  end

  // Negation is modulo 2^(WIDTH+4), which is exactly what the adder wants.
  always_comb begin
    addend = '0;
    case (sel)
      PM:      addend = m1;
      P2M:     addend = m2;
      NM:      addend = -m1;
      N2M:     addend = -m2;
      default: addend = '0;
    endcase
  end

endmodule

// File: rtl/booth_multiplier_r4.sv
// ---------------------------------------------------------------------------
// booth_multiplier_r4
// Sequential radix-4 (modified Booth) multiplier, two multiplier bits per
// cycle, signed or unsigned operands, start/busy/done handshake.
//
// Ports
//   clk          in  1         rising-edge clock
//   reset        in  1         synchronous active-high reset
//   start        in  1         request, sampled only while busy=0
//   is_signed    in  1         1: two's complement operands, 0: unsigned
//   multiplicand in  WIDTH     M, sampled with start
//   multiplier   in  WIDTH     Q, sampled with start
//   busy         out 1         high while an operation is in flight
//   done         out 1         one-cycle pulse on the completion edge
//   product      out 2*WIDTH   result, held until the next completion
//
// Configuration macro
//   BOOTH_EARLY_TERM_EN  when defined, an operation completes as soon as all
//                        remaining Booth digits are zero; the remaining
//                        shift is done in one step by a variable shifter.
// ---------------------------------------------------------------------------
module booth_multiplier_r4
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int N  = booth_iters(WIDTH);
  localparam int CW = $clog2(N + 1);
  // Full shift chain {A, Qr, q_m1}.
  localparam int TW = 2 * WIDTH + 7;
  localparam logic [CW-1:0] LAST_CNT = CW'(N);

  state_t state;
  state_t state_nxt;

  logic signed [WIDTH+3:0] acc;
  logic [WIDTH+1:0]        qr;
  logic                    qm1;
  logic [WIDTH+1:0]        mr;
  logic [CW-1:0]           cnt;

  logic [WIDTH+3:0]        addend;
  logic signed [WIDTH+3:0] sum;
  logic signed [TW-1:0]    step_full;
  logic signed [TW-1:0]    final_full;
  logic [CW-1:0]           cnt_inc;
  logic                    last_iter;
  logic                    early_hit;
  logic                    load;
  logic                    finish;
  logic [WIDTH+1:0]        m_ext;
  logic [WIDTH+1:0]        q_ext;

  // Two guard bits: sign copies in signed mode, zeros in unsigned mode, so
  // the recoder always works on a signed value with the same magnitude.
  assign m_ext = is_signed ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                           : {2'b00, multiplicand};
  assign q_ext = is_signed ? {{2{multiplier[WIDTH-1]}}, multiplier}
                           : {2'b00, multiplier};

  booth_r4_recoder #(
    .WIDTH (WIDTH)
  ) u_recoder (
    .triplet (qr[1:0] == 2'b00 && !qm1 ? 3'b000 : {qr[1:0], qm1}),
    .mr      (mr),
    .addend  (addend)
  );

  assign busy = (state == RUN);

  // One Booth iteration: add the selected multiple of M into A, then shift
  // the whole {A, Qr, q_m1} chain right by two with sign fill.
  always_comb begin
    sum       = acc + $signed(addend);
    step_full = $signed({sum, qr, qm1}) >>> 2;
    cnt_inc   = cnt + 1'b1;
    last_iter = (cnt_inc == LAST_CNT);
  end

`ifdef BOOTH_EARLY_TERM_EN
  // After this cycle's iteration, if the not-yet-recoded multiplier bits and
  // q_m1 are all the same value, every remaining digit is 0 and the rest of
  // the work is a single arithmetic shift of 2*(remaining digits).
  int rem_bits;

  always_comb begin
    rem_bits  = 2 * (N - int'(cnt_inc));
    early_hit = 1'b1;
    for (int j = 0; j < WIDTH + 2; j++) begin
      if ((j < rem_bits) && (step_full[j+1] != step_full[0])) begin
        early_hit = 1'b0;
      end
    end
    final_full = step_full;
    if (early_hit && (rem_bits > 0)) begin
      final_full = step_full >>> rem_bits;
    end
  end
`else
  always_comb begin
    early_hit  = 1'b0;
    final_full = step_full;
  end
`endif

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept start only when idle, finish after the last
  // digit (or earlier when the remaining digits are all zero).
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (last_iter || early_hit) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture on load, one iteration per RUN cycle, and the
  // product/done registers that only move on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      qr      <= '0;
      qm1     <= 1'b0;
      mr      <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= finish;
      if (load) begin
        acc <= '0;
        qr  <= q_ext;
        qm1 <= 1'b0;
        mr  <= m_ext;
        cnt <= '0;
      end else if (state == RUN) begin
        {acc, qr, qm1} <= final_full;
        cnt            <= finish ? '0 : cnt_inc;
        if (finish) begin
          product <= final_full[2*WIDTH:1];
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_multiplier_r4.sv
// ---------------------------------------------------------------------------
// tb_booth_multiplier_r4
// Self-checking bench for booth_multiplier_r4 (WIDTH=8). Expected products
// come from plain integer multiplication of the extended operands; expected
// latency comes from the Booth digit sequence of the extended multiplier.
// ---------------------------------------------------------------------------
module tb_booth_multiplier_r4;

  localparam int W = 8;
  localparam int N = W / 2 + 1;

  logic           clk;
  logic           reset;
  logic           start;
  logic           is_signed;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;

  booth_multiplier_r4 #(
    .WIDTH (W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference product: exact integer multiply of the operands, truncated.
  function automatic logic [2*W-1:0] modelProduct(input logic sgn,
                                                  input logic [W-1:0] m,
                                                  input logic [W-1:0] q);
    longint a;
    longint b;
    longint p;
    a = sgn ? longint'($signed(m)) : longint'(m);
    b = sgn ? longint'($signed(q)) : longint'(q);
    p = a * b;
    return p[2*W-1:0];
  endfunction

  // Reference latency: N without early termination; with it, the index of
  // the last nonzero Booth digit plus one (at least one cycle).
  function automatic int modelLatency(input logic sgn, input logic [W-1:0] q);
    logic [W+2:0] e;
    int           last;
    int           d;
    e    = {(sgn ? {2{q[W-1]}} : 2'b00), q, 1'b0};
    last = 0;
    for (int j = 0; j < N; j++) begin
      d = -2 * int'(e[2*j+2]) + int'(e[2*j+1]) + int'(e[2*j]);
      if (d != 0) last = j + 1;
    end
`ifdef BOOTH_EARLY_TERM_EN
    return (last < 1) ? 1 : last;
`else
    return N;
`endif
  endfunction

  // Presents one request and leaves start low after the accept edge.
  task automatic applyStimulus(input logic sgn, input logic [W-1:0] m,
                               input logic [W-1:0] q);
    @(negedge clk);
    is_signed    = sgn;
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full operation: launch, count cycles to done (bounded), check result,
  // latency and that done is a single-cycle pulse.
  task automatic runOp(input string tag, input logic sgn, input logic [W-1:0] m,
                       input logic [W-1:0] q, input logic [2*W-1:0] exp_p);
    int lat;
    applyStimulus(sgn, m, q);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(modelLatency(sgn, q)));
    checkOutput({tag, "_product"}, 32'(product), 32'(exp_p));
    checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
    checkOutput({tag, "_held"}, 32'(product), 32'(exp_p));
  endtask

  initial begin
    int lat;
    int done_cnt;
    logic [2*W-1:0] first_p;
    logic sgn;
    logic [W-1:0] m;
    logic [W-1:0] q;

    reset        = 1'b1;
    start        = 1'b0;
    is_signed    = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_product", 32'(product), 32'd0);
    reset = 1'b0;

    // Directed vectors with hand-computed products.
    runOp("s_m128_m128", 1'b1, 8'h80, 8'h80, 16'h4000);
    runOp("u_255_255",   1'b0, 8'hFF, 8'hFF, 16'hFE01);
    runOp("s_7_m3",      1'b1, 8'h07, 8'hFD, 16'hFFEB);
    runOp("u_07_fd",     1'b0, 8'h07, 8'hFD, 16'h06EB);
    runOp("s_q0",        1'b1, 8'h5A, 8'h00, 16'h0000);
    runOp("s_qm1",       1'b1, 8'h5A, 8'hFF, 16'hFFA6);
    runOp("s_q3",        1'b1, 8'h11, 8'h03, 16'h0033);

    // Starts while busy must be ignored; exactly one done, first result kept.
    applyStimulus(1'b0, 8'hC5, 8'h3B);
    done_cnt = 0;
    for (int c = 1; c <= 15; c++) begin
      if (done) done_cnt++;
      start = (c == 1 || c == 3);
      if (start) begin
        multiplicand = 8'h01;
        multiplier   = 8'h01;
        is_signed    = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
    end
    checkOutput("busy_start_done_count", 32'(done_cnt), 32'd1);
    checkOutput("busy_start_product", 32'(product), 32'h2D67);

    // Back-to-back: new start in the done cycle, old product held meanwhile.
    applyStimulus(1'b0, 8'hC5, 8'h3B);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("b2b_first_done", 32'(done), 32'd1);
    first_p      = product;
    checkOutput("b2b_first_product", 32'(first_p), 32'h2D67);
    is_signed    = 1'b0;
    multiplicand = 8'd5;
    multiplier   = 8'd6;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b_accepted", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      checkOutput("b2b_hold", 32'(product), 32'h2D67);
      @(negedge clk);
      lat++;
    end
    checkOutput("b2b_latency", 32'(lat), 32'(modelLatency(1'b0, 8'd6)));
    checkOutput("b2b_second_product", 32'(product), 32'h001E);
    @(negedge clk);

    // Reset in RUN cycle 2 discards the operation and clears outputs.
    applyStimulus(1'b0, 8'hC5, 8'h3B);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_product", 32'(product), 32'd0);
    runOp("after_reset", 1'b1, 8'hE3, 8'h2C, modelProduct(1'b1, 8'hE3, 8'h2C));

    // Random vectors against the arithmetic model.
    for (int i = 0; i < 60; i++) begin
      sgn = 1'($urandom_range(0, 1));
      m   = 8'($urandom);
      q   = 8'($urandom);
      runOp("random", sgn, m, q, modelProduct(sgn, m, q));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_multiplier_r4.md
# booth_multiplier_r4

Parametrised sequential radix-4 (modified Booth) multiplier, successor to the 6-bit radix-2 Booth multiplier. It takes two WIDTH-bit operands in signed or unsigned mode under a start/busy/done handshake. It retires two multiplier bits per cycle and holds the 2·WIDTH-bit product until the next completion. It serves as the shared multiply unit for the datapath and ALU blocks.

## Interface
- WIDTH, 8, operand width; even, ≥4.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- is_signed  in  1  1: two's-complement operands; 0: unsigned. Sampled with start.
- multiplicand  in  WIDTH  M; sampled with start.
- multiplier  in  WIDTH  Q; sampled with start.
- busy  out  1  high from the start-accept edge until the completion edge.
- done  out  1  one-cycle pulse on the completion edge.
- product  out  2·WIDTH  result; updated only at completion, held otherwise.

## Operation
- Constant N = WIDTH/2+1 iterations.
- Operands are extended to WIDTH+2 bits: sign-extended if is_signed, else zero-extended.
- Registers:
  - A: WIDTH+4 bits, signed, cleared at load.
  - Qr: WIDTH+2 bits, holds the extended multiplier.
  - q_m1: 1 bit, cleared at load.
  - Mr: extended multiplicand.
  - cnt: ⌈log2(N+1)⌉ bits.
- States: IDLE, RUN.
  - IDLE→RUN on start. All operands are latched and busy is set.
  - RUN→IDLE at completion. product, done and busy update.
- Each RUN cycle, recode {Qr[1:0],q_m1}:
  - 000, 111 → 0
  - 001, 010 → +M
  - 011 → +2M
  - 100 → −2M
  - 101, 110 → −M
- After the add, arithmetic-shift {A,Qr,q_m1} right by 2. cnt increments.
- Completion after N iterations: product = low 2·WIDTH bits of {A,Qr}.
- This yields the exact signed product of the extended operands. It is exact for both modes; overflow is impossible.
- Start while busy=1 is ignored; no queuing.
- Operand input changes while busy have no effect.
- Reset in any state, including mid-RUN:
  - state IDLE; busy=0, done=0, product=0, cnt=0.
  - The in-flight operation is discarded.

## Timing
- Reset values: busy=0, done=0, product=0.
- Start accepted at edge k.
  - busy=1 after edge k.
  - Iterations at edges k+1…k+N.
  - done=1, busy=0 and product valid after edge k+N.
  - Latency is N cycles (5 for WIDTH=8) without early termination.
- done is high for exactly one cycle.
- start high in the done cycle (busy=0) is accepted, giving back-to-back operation. Throughput is one result per N+1 cycles.
- start and reset in the same cycle: reset wins.

## Configuration
- BOOTH_EARLY_TERM_EN defined: early termination.
  - Each RUN cycle, after i completed iterations, check whether Qr[2(N−i)−1:0] and q_m1 are all equal.
  - If so, every remaining digit is 0. That cycle performs one arithmetic right shift by 2(N−i) and completes.
  - Latency is 1…N cycles. Results are identical to the non-EN build.
- Undefined: no check; latency is fixed at N. The variable shifter is absent.

## Structure
- Package booth_pkg holds:
  - state encoding (IDLE, RUN);
  - the 3-bit digit-select encoding (ZERO, PM, P2M, NM, N2M);
  - the function computing N from WIDTH.
- Sub-module booth_r4_recoder (combinational): takes {Qr[1:0],q_m1} and Mr; returns the (WIDTH+4)-bit addend 0/±M/±2M.
- Top holds the FSM, counter and the A/Qr/q_m1 shift register.

## Test plan
- WIDTH=8, signed, −128 × −128 → product 0x4000. done exactly 5 cycles after the start edge (non-EN).
- Unsigned 255 × 255 → 0xFE01. Signed 7 × −3 → 0xFFEB. Unsigned 0x07 × 0xFD → 0x06EB.
- Start pulsed at busy cycles 1 and 3 with new operands → ignored. The first result is unchanged and done fires once.
- start asserted in the done cycle with 5 × 6 → accepted. Second done after 5 more cycles with 0x001E; the first product was held until then.
- reset asserted at RUN cycle 2 → next cycle busy=0, done=0, product=0. A fresh start then completes normally.
- BOOTH_EARLY_TERM_EN:
  - signed multiplier 0 or −1 → done 1 cycle after start, product 0 or −M.
  - multiplier 3 → done in 2 cycles.
  - random 10k-vector comparison against the non-EN build is bit-identical.
